// File: rtl/pwm_cmd_ramp.sv
// pwm_cmd_ramp: conditions signed speed commands for a PWM motor driver.
// Slew-limits duty once per PWM tick, inserts a braking ramp plus dead
// interval before any direction reversal, and stops the motor if the
// command source goes silent for too long.
//
// Handshake: cmd_ready is held at 1 from the first edge after reset; a
// command transfers on every cycle where cmd_valid & cmd_ready are both 1
// and its fields are latched on that edge. There is no back-pressure, so
// the last command before a tick is the one the tick acts on.
module pwm_cmd_ramp #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int PWM_FREQ       = 20_000,
  parameter int COUNTER_W      = 12,
  parameter int STEP           = 16,
  parameter int REV_DEAD_TICKS = 4,
  parameter int WDT_TICKS      = 2000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [COUNTER_W:0]   cmd_value,
  input  logic                 cmd_arm,
  output logic                 enable,
  output logic [COUNTER_W-1:0] duty_cycle,
  output logic                 direction,
  output logic                 at_target,
  output logic                 fault_timeout,
  output logic [2:0]           dbg_state
);

  localparam int DIV = CLK_FREQ / PWM_FREQ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int WW  = $clog2(WDT_TICKS + 2);
  localparam int DW  = $clog2(REV_DEAD_TICKS + 2);
  localparam logic [PW-1:0]        PRE_LAST = PW'(DIV - 1);
  localparam logic [WW-1:0]        WDT_LAST = WW'(WDT_TICKS - 1);
  localparam logic [DW-1:0]        DEAD_END = DW'(REV_DEAD_TICKS);
  localparam logic [COUNTER_W:0]   STEP_W   = (COUNTER_W + 1)'(STEP);
  localparam logic [COUNTER_W-1:0] MAG_MAX  = '1;

  // IDLE is encoded 0 so the debug view reads 0 straight out of reset.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_BRAKE = 3'd2,
    S_DEAD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t               state;
  logic [PW-1:0]        presc;
  logic [WW-1:0]        wdt_cnt;
  logic [DW-1:0]        dead_cnt;
  logic [COUNTER_W-1:0] tgt_mag;
  logic                 tgt_dir;
  logic                 armed;

  logic                 tick;
  logic                 accept;
  logic                 cmd_neg;
  logic [COUNTER_W:0]   cmd_abs;
  logic [COUNTER_W-1:0] cmd_mag;
  logic                 cmd_dir;
  logic [COUNTER_W-1:0] eff_mag;
  logic                 eff_dir;
  logic                 eff_armed;
  logic                 in_motion;
  logic                 wdt_counting;
  logic                 wdt_fire;
  logic [COUNTER_W-1:0] duty_down;
  logic [COUNTER_W-1:0] duty_next;
  logic [COUNTER_W-1:0] duty_start;

  // One slew step from cur toward tgt, done one bit wider so it cannot wrap.
  function automatic logic [COUNTER_W-1:0] ramp_to(input logic [COUNTER_W-1:0] cur,
                                                   input logic [COUNTER_W-1:0] tgt);
    logic [COUNTER_W:0] c, t, up, dn;
    c  = {1'b0, cur};
    t  = {1'b0, tgt};
    up = c + STEP_W;
    dn = c - STEP_W;
    if (c < t)      ramp_to = (up > t) ? tgt : up[COUNTER_W-1:0];
    else if (c > t) ramp_to = ((c < STEP_W) || (dn < t)) ? tgt : dn[COUNTER_W-1:0];
    else            ramp_to = cur;
  endfunction

  assign tick    = (presc == PRE_LAST);
  assign accept  = cmd_valid & cmd_ready;
  assign cmd_neg = cmd_value[COUNTER_W];
  assign cmd_abs = cmd_neg ? (~cmd_value + 1'b1) : cmd_value;
  // Only -2^COUNTER_W has an absolute value that sets the top bit.
  assign cmd_mag = cmd_abs[COUNTER_W] ? MAG_MAX : cmd_abs[COUNTER_W-1:0];
  // A zero command carries no sign, so the existing target direction stays.
  assign cmd_dir = (cmd_value == '0) ? tgt_dir : cmd_neg;

  // A command arriving with a tick is applied before the tick acts.
  assign eff_mag   = accept ? cmd_mag : tgt_mag;
  assign eff_dir   = accept ? cmd_dir : tgt_dir;
  assign eff_armed = accept ? cmd_arm : armed;

  assign in_motion    = (state == S_RUN) || (state == S_BRAKE) || (state == S_DEAD);
  assign wdt_counting = in_motion || ((state == S_IDLE) && eff_armed);
  assign wdt_fire     = (WDT_TICKS != 0) && tick && !accept && in_motion &&
                        (wdt_cnt == WDT_LAST);

  assign duty_down  = ramp_to(duty_cycle, '0);
  assign duty_next  = ramp_to(duty_cycle, eff_mag);
  assign duty_start = ramp_to('0, eff_mag);

  assign dbg_state = state;

  // Prescaler, command latch, watchdog and the tick-driven output FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      presc         <= '0;
      wdt_cnt       <= '0;
      dead_cnt      <= '0;
      tgt_mag       <= '0;
      tgt_dir       <= 1'b0;
      armed         <= 1'b0;
      cmd_ready     <= 1'b0;
      enable        <= 1'b0;
      duty_cycle    <= '0;
      direction     <= 1'b0;
      at_target     <= 1'b0;
      fault_timeout <= 1'b0;
    end else begin
      cmd_ready <= 1'b1;
      presc     <= tick ? '0 : presc + 1'b1;
      at_target <= (state == S_RUN) && armed && (duty_cycle == tgt_mag) &&
                   (direction == tgt_dir);

      if (accept) begin
        tgt_mag <= cmd_mag;
        tgt_dir <= cmd_dir;
        armed   <= cmd_arm;
      end

      if (accept)    wdt_cnt <= '0;
      else if (tick) wdt_cnt <= wdt_counting ? wdt_cnt + 1'b1 : '0;

      if (tick) begin
        if (wdt_fire) begin
          state         <= S_FAULT;
          fault_timeout <= 1'b1;
          armed         <= 1'b0;
          duty_cycle    <= duty_down;
        end else if (state == S_IDLE) begin
          if (eff_armed) begin
            state         <= S_RUN;
            enable        <= 1'b1;
            direction     <= eff_dir;
            fault_timeout <= 1'b0;
            duty_cycle    <= duty_start;
          end else begin
            enable     <= 1'b0;
            duty_cycle <= '0;
          end
        end else if ((state == S_FAULT) || !eff_armed) begin
          // Stopping: ramp to zero, then drop enable one tick later.
          if (duty_cycle == '0) begin
            state  <= S_IDLE;
            enable <= 1'b0;
          end else begin
            duty_cycle <= duty_down;
          end
        end else begin
          case (state)
            S_RUN: begin
              if ((eff_mag != '0) && (eff_dir != direction)) begin
                duty_cycle <= duty_down;
                dead_cnt   <= '0;
                state      <= (duty_down == '0) ? S_DEAD : S_BRAKE;
              end else begin
                duty_cycle <= duty_next;
              end
            end
            S_BRAKE: begin
              if (eff_dir == direction) begin
                state <= S_RUN;
              end else begin
                duty_cycle <= duty_down;
                if (duty_down == '0) begin
                  state    <= S_DEAD;
                  dead_cnt <= '0;
                end
              end
            end
            S_DEAD: begin
              if (dead_cnt == DEAD_END) begin
                direction <= eff_dir;
                state     <= S_RUN;
              end else begin
                dead_cnt <= dead_cnt + 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/pwm_cmd_ramp.md
# pwm_cmd_ramp

Command conditioner that sits directly upstream of the PWM motor driver and owns its `enable`, `duty_cycle` and `direction` inputs. It accepts signed speed commands over a valid/ready handshake. It slew-limits the duty cycle once per PWM period, and forces a ramp-to-zero plus dead interval before any direction reversal. A command watchdog safely brings the motor to a stop if the command source goes silent.

## Interface
- `CLK_FREQ`, 50_000_000, system clock in Hz
- `PWM_FREQ`, 20_000, update rate in Hz; one update tick every CLK_FREQ/PWM_FREQ cycles (2500)
- `COUNTER_W`, 12, duty width; must match the PWM driver
- `STEP`, 16, maximum duty change per tick
- `REV_DEAD_TICKS`, 4, ticks held at duty 0 before a direction flip
- `WDT_TICKS`, 2000, ticks without an accepted command before fault; 0 disables the watchdog

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_value`  in  COUNTER_W+1  signed two's-complement command; negative means CCW
- `cmd_arm`  in  1  sampled with the command; 0 requests stop and disable
- `enable`  out  1  to the PWM driver
- `duty_cycle`  out  COUNTER_W  to the PWM driver
- `direction`  out  1  to the PWM driver; 0 = CW, 1 = CCW
- `at_target`  out  1  duty and direction equal the target, in RUN state
- `fault_timeout`  out  1  sticky watchdog fault flag

## Operation
- **Accept and latch.** A command is accepted on any cycle with `cmd_valid & cmd_ready`. The target magnitude, target direction and armed flag are latched on that edge.
- **Magnitude.** Magnitude is |cmd_value|. The value -2^COUNTER_W saturates to 2^COUNTER_W-1.
- **Direction of a zero command.** A command of 0 keeps the current target direction.
- **Ramp arithmetic.**
  - Computed in COUNTER_W+1 bits, so it never wraps.
  - If duty < target: duty ← min(duty+STEP, target).
  - If duty > target: duty ← max(duty−STEP, target).
- **States.**
  - **IDLE.** enable=0, duty=0. An accepted armed command moves to RUN. At the next tick: enable=1, direction = command sign, ramping starts from 0.
  - **RUN.** Ramps toward the target.
    - A nonzero command with the opposite direction moves to BRAKE.
    - Other commands update the target only.
  - **BRAKE.** Ramps toward 0.
    - On the tick where duty becomes 0, move to DEAD.
    - A command matching the current direction returns to RUN and keeps the present duty.
  - **DEAD.** duty=0 for REV_DEAD_TICKS ticks. Then direction flips to the pending direction and the state is RUN. With REV_DEAD_TICKS=0 the flip occurs on the next tick.
  - **FAULT.** The target is forced to 0 and duty ramps down. `fault_timeout`=1.
- **Disarm** (accepted command with `cmd_arm`=0, from any non-IDLE state):
  - The target is forced to 0 and duty ramps down.
  - At the tick after duty reaches 0: enable=0 and the state is IDLE.
- **Leaving FAULT.** The state is the same as IDLE once duty=0, and stays there until an accepted armed command arrives. That command clears `fault_timeout` and enters RUN.
- **Watchdog.**
  - The tick counter resets on every accepted command.
  - Reaching WDT_TICKS in RUN, BRAKE or DEAD enters FAULT.
  - The counter does not run in IDLE.
- **Command in the same cycle as a tick.** The command is latched first. The tick then uses the new target.
- **Reset values:** enable=0, duty_cycle=0, direction=0, at_target=0, fault_timeout=0, cmd_ready=0, state IDLE, prescaler 0.

## Timing
- **Prescaler.** Counts 0..CLK_FREQ/PWM_FREQ−1. The tick pulses for one cycle at the terminal count. The first tick is 2500 cycles after reset is released.
- **Output update rule.** `enable`, `duty_cycle` and `direction` change only on the clock edge that consumes a tick, never between ticks. This guarantees glitch-free updates into the PWM driver.
- **cmd_ready.** Rises on the first edge after reset is released. It is then held at 1; every command is accepted in one cycle, and the last command before a tick wins.
- **at_target.** Registered. Valid in the cycle after the output update.
- **Asynchronous reset.** Reset forces every output to its reset value immediately, including mid-ramp and mid-dead-time.

## Test plan
- **Ramp up, CW.** Reset, then armed command +1024.
  - enable=1 and duty=16 at tick 1.
  - duty=1024 at tick 64, with at_target=1 and direction=0.
- **Reversal.** From +1024 steady, command −3072.
  - duty reaches 0 at tick 64 (BRAKE).
  - duty holds 0 for 4 ticks with direction=0.
  - direction=1 at the flip.
  - duty=3072 after a further 192 ticks.
- **Saturation.** Armed command −4096 → target 4095 and direction=1. The final ramp step clamps to exactly 4095, never 4096 or a wrapped value.
- **Watchdog.** From +512 steady, no commands sent.
  - fault_timeout=1 at tick 2000 after the last acceptance.
  - duty ramps to 0 in 32 ticks, then enable=0.
  - A new armed +256 command clears the fault and ramps up.
- **Disarm mid-ramp.** At duty=800, send command 0 with arm=0.
  - duty reaches 0 after 50 ticks.
  - enable=0 one tick later; direction unchanged.
- **Reset mid-ramp.** Assert reset between ticks at duty=400.
  - enable, duty_cycle and at_target are 0 in the same cycle, without waiting for a clock edge.
  - First tick is 2500 cycles after release.
